// File: rtl/sdram_frame_reader.sv
// Streams one RGB565 frame per VGA frame-start from a double-buffered SDRAM region
// into the pixel FIFO, acting as a pipelined Avalon-MM read master with credit flow control.
module sdram_frame_reader #(
  parameter int          H_ACTIVE    = 800,
  parameter int          V_ACTIVE    = 600,
  parameter logic [24:0] BUF0_BASE   = 25'h0000000,
  parameter logic [24:0] BUF1_BASE   = 25'h0080000,
  parameter int          FIFO_DEPTH  = 512,
  parameter int          FIFO_MARGIN = 4,
  parameter int          MAX_PENDING = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic                          bufferselect,
  output logic [24:0]                   avm_address,
  output logic                          avm_read,
  input  logic                          avm_waitrequest,
  input  logic [15:0]                   avm_readdata,
  input  logic                          avm_readdatavalid,
  output logic [15:0]                   fifo_data,
  output logic                          fifo_wrreq,
  input  logic [$clog2(FIFO_DEPTH)-1:0] fifo_wrusedw,
  input  logic                          fifo_wrfull,
  output logic                          busy,
  output logic                          frame_overrun,
  output logic                          fifo_overflow
);
  localparam int PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

  state_t      state_reg, state_next;
  logic        fs_s1_reg, fs_s2_reg, fs_prev_reg, bs_s1_reg, bs_s2_reg;
  logic [18:0] issued_reg, issued_next;
  logic [4:0]  pending_reg, pending_next;
  logic [24:0] base_reg, base_next, address_next;
  logic        accept, stalled, returned, fs_rise, live;
  logic        start_frame, overrun_next, can_issue, read_next, overflow_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs_s1_reg   <= 1'b0;
      fs_s2_reg   <= 1'b0;
      fs_prev_reg <= 1'b0;
      bs_s1_reg   <= 1'b0;
      bs_s2_reg   <= 1'b0;
    end else begin
      fs_s1_reg   <= frame_start;
      fs_s2_reg   <= fs_s1_reg;
      fs_prev_reg <= fs_s2_reg;
      bs_s1_reg   <= bufferselect;
      bs_s2_reg   <= bs_s1_reg;
    end
  end

  assign fs_rise  = fs_s2_reg & ~fs_prev_reg;
  assign accept   = avm_read & ~avm_waitrequest;
  assign stalled  = avm_read & avm_waitrequest;
  // Returns with nothing outstanding (e.g. stragglers after reset) must not underflow the credit count
  assign returned = avm_readdatavalid && (pending_reg != 5'd0);
  assign pending_next = pending_reg + {4'd0, accept} - {4'd0, returned};

  assign live       = (state_reg == READ) || (state_reg == DRAIN);
  assign fifo_wrreq = live & avm_readdatavalid;
  assign fifo_data  = live ? avm_readdata : 16'd0;

  always_comb begin
    state_next   = state_reg;
    start_frame  = 1'b0;
    overrun_next = frame_overrun;
    case (state_reg)
      IDLE: begin
        if (fs_rise) start_frame = 1'b1;
      end
      READ: begin
        if (fs_rise) begin
          overrun_next = 1'b1;
          state_next   = FLUSH;
        end else if (accept && issued_reg == 19'(PIXELS - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A frame start coinciding with the final return simply begins the next frame
        if (pending_next == 5'd0) begin
          if (fs_rise) start_frame = 1'b1;
          else         state_next  = IDLE;
        end else if (fs_rise) begin
          overrun_next = 1'b1;
          state_next   = FLUSH;
        end
      end
      FLUSH: begin
        if (pending_next == 5'd0 && !stalled) start_frame = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (start_frame) state_next = READ;

    base_next   = start_frame ? (bs_s2_reg ? BUF1_BASE : BUF0_BASE) : base_reg;
    issued_next = start_frame ? 19'd0 : issued_reg + {18'd0, accept};

    // Decision is for next cycle's request, so it uses post-update credits
    can_issue = (state_next == READ) &&
                (issued_next < 19'(PIXELS)) &&
                (pending_next < 5'(MAX_PENDING)) &&
                (32'(fifo_wrusedw) + 32'(pending_next) < 32'(FIFO_DEPTH - FIFO_MARGIN));
    read_next     = stalled | can_issue;
    address_next  = stalled ? avm_address : base_next + 25'(issued_next);
    overflow_next = fifo_overflow | (fifo_wrreq & fifo_wrfull);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      issued_reg    <= 19'd0;
      pending_reg   <= 5'd0;
      base_reg      <= 25'd0;
      avm_read      <= 1'b0;
      avm_address   <= 25'd0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      state_reg     <= state_next;
      issued_reg    <= issued_next;
      pending_reg   <= pending_next;
      base_reg      <= base_next;
      avm_read      <= read_next;
      avm_address   <= address_next;
      busy          <= (state_next != IDLE);
      frame_overrun <= overrun_next;
      fifo_overflow <= overflow_next;
    end
  end

endmodule
